// File: rtl/alu_op_sequencer.sv
// ALU operand/control sequencer.
// Takes a two-byte command from the host (operand byte, then control byte),
// drives a multi-cycle ALU, samples its result ALU_LAT cycles after the
// control byte and holds it for the host under a valid/ready handshake.
// Optional build macro: ALU_SEQ_ERRCHK_EN -- reject control bytes whose
// reserved bits [7:6] are non-zero (sets err, returns to IDLE, no result).

module alu_op_sequencer #(
    parameter int unsigned ALU_LAT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [1:0] alu_c,
    output logic [1:0] alu_opcode,
    output logic [1:0] alu_inmode,
    input  logic [9:0] alu_result,
    output logic [9:0] res_data,
    output logic       res_valid,
    input  logic       res_ready,
    output logic       busy,
    output logic       err
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ALU_LAT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GET_CTRL = 2'd1,
        ISSUE    = 2'd2,
        RESP     = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             byte_xfer;
    logic             ctrl_bad;

    // Byte acceptance window: only while collecting bytes and never in reset.
    assign in_ready  = !rst && ((state == IDLE) || (state == GET_CTRL));
    assign byte_xfer = in_valid && in_ready;
    assign busy      = (state != IDLE);

`ifdef ALU_SEQ_ERRCHK_EN
    // Reserved control bits must be zero for the command to be executed.
    assign ctrl_bad = (in_data[7:6] != 2'b00);
`else
    // Reserved control bits are don't-care in this build.
    logic unused_rsv_bits;
    assign unused_rsv_bits = ^in_data[7:6];
    assign ctrl_bad        = 1'b0;
`endif

    // Sequencer FSM with all datapath outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            alu_a      <= 4'd0;
            alu_b      <= 4'd0;
            alu_c      <= 2'd0;
            alu_opcode <= 2'd0;
            alu_inmode <= 2'd0;
            res_data   <= 10'd0;
            res_valid  <= 1'b0;
            err        <= 1'b0;
            cnt        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (byte_xfer) begin
                        alu_a <= in_data[7:4];
                        alu_b <= in_data[3:0];
                        err   <= 1'b0;
                        state <= GET_CTRL;
                    end
                end
                GET_CTRL: begin
                    if (byte_xfer) begin
                        if (ctrl_bad) begin
                            // Rejected command: keep previous control fields.
                            err   <= 1'b1;
                            state <= IDLE;
                        end else begin
                            alu_inmode <= in_data[1:0];
                            alu_opcode <= in_data[3:2];
                            alu_c      <= in_data[5:4];
                            cnt        <= CNT_LOAD;
                            state      <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    // Counter reaching 1 marks the edge ALU_LAT after issue.
                    cnt <= cnt - CNT_LAST;
                    if (cnt == CNT_LAST) begin
                        res_data  <= alu_result;
                        res_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: three instances (ALU_LAT = 2, 1, 15) share clk/rst.
// The ALU stub returns a value that is a known function of the cycle index, so
// the expected result also pins down the exact sampling edge.
// Honours ALU_SEQ_ERRCHK_EN the same way the design does.

module tb_alu_op_sequencer;

    localparam int NL = 3;

`ifdef ALU_SEQ_ERRCHK_EN
    localparam bit ERRCHK = 1'b1;
`else
    localparam bit ERRCHK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data   [NL];
    logic       in_valid  [NL];
    logic       in_ready  [NL];
    logic [3:0] alu_a     [NL];
    logic [3:0] alu_b     [NL];
    logic [1:0] alu_c     [NL];
    logic [1:0] alu_opcode[NL];
    logic [1:0] alu_inmode[NL];
    logic [9:0] res_data  [NL];
    logic       res_valid [NL];
    logic       res_ready [NL];
    logic       busy      [NL];
    logic       err       [NL];
    logic [9:0] alu_result;

    int         cyc = 0;
    bit         stub_en = 1'b0;
    logic [9:0] stub_val = 10'd0;
    int         rr_mode [NL];
    int         total = 0;
    int         bad = 0;

    typedef struct {
        int         lane;
        int         due;
        logic [9:0] res;
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] c;
        logic [1:0] op;
        logic [1:0] im;
    } exp_t;

    exp_t       sbq[$];
    logic [3:0] m_a [NL];
    logic [3:0] m_b [NL];
    logic [1:0] m_c [NL];
    logic [1:0] m_op[NL];
    logic [1:0] m_im[NL];
    bit         prev_rv[NL];
    logic [9:0] held[NL];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 1 : 15);
    endfunction

    function automatic logic [9:0] hash(input int n);
        logic [31:0] t;
        t = (n * 97) ^ (n >>> 3) ^ 32'h15A;
        return t[9:0];
    endfunction

    assign alu_result = stub_en ? stub_val : hash(cyc);

    for (genvar g = 0; g < NL; g++) begin : g_dut
        localparam int unsigned LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 15);
        alu_op_sequencer #(.ALU_LAT(LAT)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_data   (in_data[g]),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .alu_a     (alu_a[g]),
            .alu_b     (alu_b[g]),
            .alu_c     (alu_c[g]),
            .alu_opcode(alu_opcode[g]),
            .alu_inmode(alu_inmode[g]),
            .alu_result(alu_result),
            .res_data  (res_data[g]),
            .res_valid (res_valid[g]),
            .res_ready (res_ready[g]),
            .busy      (busy[g]),
            .err       (err[g])
        );
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Host result-side: 0 = hold low, 1 = random, 2 = always ready.
    always @(posedge clk) begin
        #2;
        for (int k = 0; k < NL; k++) begin
            case (rr_mode[k])
                0:       res_ready[k] = 1'b0;
                1:       res_ready[k] = 1'($urandom_range(0, 1));
                default: res_ready[k] = 1'b1;
            endcase
        end
    end

    // Monitor: pop the scoreboard whenever a lane presents a new result.
    always @(negedge clk) begin
        exp_t me;
        for (int k = 0; k < NL; k++) begin
            if (!rst && res_valid[k]) begin
                if (!prev_rv[k]) begin
                    if (sbq.size() == 0) begin
                        chk("unexpected_result", 1, 0);
                    end else begin
                        me = sbq.pop_front();
                        chk("result_lane", k, me.lane);
                        chk("result_cycle", cyc, me.due + 1);
                        chk("res_data", int'(res_data[k]), int'(me.res));
                        chk("alu_a", int'(alu_a[k]), int'(me.a));
                        chk("alu_b", int'(alu_b[k]), int'(me.b));
                        chk("alu_c", int'(alu_c[k]), int'(me.c));
                        chk("alu_opcode", int'(alu_opcode[k]), int'(me.op));
                        chk("alu_inmode", int'(alu_inmode[k]), int'(me.im));
                        chk("err_on_result", int'(err[k]), 0);
                    end
                end else begin
                    chk("res_hold", int'(res_data[k]), int'(held[k]));
                end
                chk("in_ready_in_resp", int'(in_ready[k]), 0);
                held[k] = res_data[k];
            end
            prev_rv[k] = rst ? 1'b0 : res_valid[k];
        end
    end

    task automatic model_reset();
        sbq.delete();
        for (int k = 0; k < NL; k++) begin
            m_a[k] = 4'd0; m_b[k] = 4'd0; m_c[k] = 2'd0; m_op[k] = 2'd0; m_im[k] = 2'd0;
        end
    endtask

    task automatic chk_zero(input int k);
        chk("rst_alu_a", int'(alu_a[k]), 0);
        chk("rst_alu_b", int'(alu_b[k]), 0);
        chk("rst_alu_c", int'(alu_c[k]), 0);
        chk("rst_alu_opcode", int'(alu_opcode[k]), 0);
        chk("rst_alu_inmode", int'(alu_inmode[k]), 0);
        chk("rst_res_data", int'(res_data[k]), 0);
        chk("rst_res_valid", int'(res_valid[k]), 0);
        chk("rst_err", int'(err[k]), 0);
        chk("rst_busy", int'(busy[k]), 0);
    endtask

    // Offer one byte; called just after a rising edge, returns just after the transfer edge.
    task automatic send_byte(input int k, input logic [7:0] b, output int e, output bit ok);
        ok = 1'b0;
        e  = 0;
        in_data[k]  = b;
        in_valid[k] = 1'b1;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (in_ready[k]) begin
                e  = cyc;
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
            if (ok) break;
        end
        in_valid[k] = 1'b0;
        if (!ok) chk("send_timeout", 0, 1);
    endtask

    // Issue a full command and record what the host expects back.
    task automatic issue(input int k, input logic [7:0] b0, input logic [7:0] b1, output bit ok);
        int   e;
        bit   rej;
        exp_t me;
        send_byte(k, b0, e, ok);
        if (!ok) return;
        m_a[k] = b0[7:4];
        m_b[k] = b0[3:0];
        chk("err_clear_on_byte0", int'(err[k]), 0);
        send_byte(k, b1, e, ok);
        if (!ok) return;
        rej = ERRCHK && (b1[7:6] != 2'b00);
        if (!rej) begin
            m_c[k]  = b1[5:4];
            m_op[k] = b1[3:2];
            m_im[k] = b1[1:0];
            me.lane = k;
            me.due  = e + lat_of(k);
            me.res  = stub_en ? stub_val : hash(e + lat_of(k));
            me.a = m_a[k]; me.b = m_b[k]; me.c = m_c[k]; me.op = m_op[k]; me.im = m_im[k];
            sbq.push_back(me);
        end
        chk("ctrl_alu_a", int'(alu_a[k]), int'(m_a[k]));
        chk("ctrl_alu_b", int'(alu_b[k]), int'(m_b[k]));
        chk("ctrl_alu_c", int'(alu_c[k]), int'(m_c[k]));
        chk("ctrl_alu_opcode", int'(alu_opcode[k]), int'(m_op[k]));
        chk("ctrl_alu_inmode", int'(alu_inmode[k]), int'(m_im[k]));
        chk("ctrl_err", int'(err[k]), rej ? 1 : 0);
        chk("ctrl_busy", int'(busy[k]), rej ? 0 : 1);
    endtask

    task automatic wait_done(input int k);
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 300; t++) begin
            if (!busy[k] && sbq.size() == 0) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("done_timeout", int'(ok), 1);
    endtask

    task automatic wait_valid(input int k);
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 40; t++) begin
            if (res_valid[k]) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("valid_timeout", int'(ok), 1);
    endtask

    task automatic txn(input int k, input logic [7:0] b0, input logic [7:0] b1);
        bit ok;
        issue(k, b0, b1, ok);
        if (ok) wait_done(k);
    endtask

    initial begin
        bit         ok;
        logic [7:0] b0;
        logic [7:0] b1;
        for (int k = 0; k < NL; k++) begin
            in_data[k] = 8'd0; in_valid[k] = 1'b0; res_ready[k] = 1'b0;
            rr_mode[k] = 0; prev_rv[k] = 1'b0; held[k] = 10'd0;
        end
        model_reset();

        // Reset state and first cycle after release.
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < NL; k++) begin
            chk_zero(k);
            chk("in_ready_in_rst", int'(in_ready[k]), 0);
        end
        rst = 1'b0;
        #1;
        for (int k = 0; k < NL; k++) begin
            chk("in_ready_after_rst", int'(in_ready[k]), 1);
            chk("busy_after_rst", int'(busy[k]), 0);
        end
        @(posedge clk);
        #1;

        // Basic command with a fixed stub result, then held under backpressure.
        stub_en  = 1'b1;
        stub_val = 10'h2A5;
        issue(0, 8'h5A, 8'h27, ok);
        chk("basic_alu_a", int'(alu_a[0]), 5);
        chk("basic_alu_b", int'(alu_b[0]), 10);
        chk("basic_alu_c", int'(alu_c[0]), 2);
        chk("basic_alu_opcode", int'(alu_opcode[0]), 1);
        chk("basic_alu_inmode", int'(alu_inmode[0]), 3);
        wait_valid(0);
        in_data[0]  = 8'h99;
        in_valid[0] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            stub_val = 10'($urandom);
            @(posedge clk);
            #1;
            chk("bp_in_ready", int'(in_ready[0]), 0);
            chk("bp_res_valid", int'(res_valid[0]), 1);
            chk("bp_res_data", int'(res_data[0]), 'h2A5);
            chk("bp_alu_a", int'(alu_a[0]), 5);
        end
        in_valid[0] = 1'b0;
        rr_mode[0]  = 2;
        @(posedge clk);
        #1;
        chk("release_busy", int'(busy[0]), 0);
        chk("release_res_valid", int'(res_valid[0]), 0);
        chk("release_res_data", int'(res_data[0]), 'h2A5);
        chk("release_in_ready", int'(in_ready[0]), 1);
        stub_en = 1'b0;

        // Latency extremes.
        rr_mode[1] = 2;
        rr_mode[2] = 2;
        txn(1, 8'hFF, 8'h00);
        txn(2, 8'hFF, 8'h00);

        // Reset while a long-latency command is in flight.
        issue(2, 8'hAB, 8'h01, ok);
        repeat (4) @(posedge clk);
        #1;
        chk("midop_busy_before_rst", int'(busy[2]), 1);
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        chk_zero(2);
        rst = 1'b0;
        #1;
        chk("midop_in_ready", int'(in_ready[2]), 1);
        repeat (20) @(posedge clk);
        #1;
        txn(2, 8'h12, 8'h0C);

        // Reset on the same edge as the result handshake.
        rr_mode[0] = 0;
        issue(0, 8'h3D, 8'h1E, ok);
        wait_valid(0);
        rr_mode[0] = 2;
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        chk("simul_res_valid", int'(res_valid[0]), 0);
        chk("simul_res_data", int'(res_data[0]), 0);
        chk("simul_busy", int'(busy[0]), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Reserved control bits, then a clean command afterwards.
        txn(0, 8'h3C, 8'hC3);
        txn(0, 8'h77, 8'h01);

        // Randomized commands with random host readiness.
        rr_mode[0] = 1;
        for (int i = 0; i < 40; i++) begin
            b0 = 8'($urandom);
            b1 = 8'($urandom);
            if ($urandom_range(0, 3) != 0) b1[7:6] = 2'b00;
            txn(0, b0, b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
